imem_load_ctrl: RTL

Boot and reload controller for the single-port instruction memory of the single-cycle RISC-V core. It owns the memory address, write-data and write-enable lines. It streams program words from a loader interface into consecutive word addresses while holding the core in reset, then hands the address port to the core PC. The memory is word-indexed by A[31:2], asynchronous read, with a synchronous write port added that is driven by this block.

---
 rtl/imem_load_ctrl_if.sv | 11 +
 rtl/imem_load_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl_if.sv
// Loader handshake bundle between a program source (master) and imem_load_ctrl (slave).
interface imem_load_ctrl_if;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (output ld_start, ld_valid, ld_data, ld_last, input  ld_ready);
  modport slave  (input  ld_start, ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot/reload controller: streams loader words into instruction memory while the core sits in reset.
// Define IMEM_LD_CHECKSUM_EN to build a running 32-bit wrap-around sum of loaded words on ld_sum_o.
module imem_load_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RELEASE_CYC = 2,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  imem_load_ctrl_if.slave     ld,
  input  logic [31:0]         cpu_pc_i,
  output logic [31:0]         mem_a_o,
  output logic [31:0]         mem_wd_o,
  output logic                mem_we_o,
  output logic                cpu_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [CW-1:0]       word_cnt_o,
  output logic [31:0]         ld_sum_o
);

  localparam int unsigned FW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          xfer;
  logic          load_go;
  logic          last_slot;
  logic [31:0]   load_addr;

  assign last_slot = (word_cnt_q == CW'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    flush_d    = flush_q;
    done_d     = done_q;
    err_d      = err_q;
    xfer       = 1'b0;
    load_go    = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (ld.ld_start) begin
          load_go    = 1'b1;
          state_d    = S_LOAD;
          word_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld.ld_valid) begin
          xfer = 1'b1;
          if (word_cnt_q != CW'(DEPTH)) word_cnt_d = word_cnt_q + 1'b1;
          // The final slot ends the load whether or not the source flagged it.
          if (ld.ld_last || last_slot) begin
            state_d = S_FLUSH;
            flush_d = '0;
          end
          if (!ld.ld_last && last_slot) err_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_q == FW'(RELEASE_CYC - 1)) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      flush_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Control outputs decode the registered state only; ld_valid never reaches cpu_rst.
  assign cpu_rst_o   = (state_q != S_RUN);
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign ld.ld_ready = (state_q == S_LOAD);
  assign mem_we_o    = xfer & ~reset;
  assign mem_wd_o    = ld.ld_data;
  assign load_addr   = BASE_ADDR + 32'({word_cnt_q, 2'b00});
  assign mem_a_o     = (state_q == S_RUN) ? cpu_pc_i : load_addr;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = word_cnt_q;

`ifdef IMEM_LD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_go)   sum_d = '0;
    else if (xfer) sum_d = sum_q + ld.ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign ld_sum_o = sum_q;
`else
  assign ld_sum_o = 32'h0;
`endif

endmodule
